zeroskip_expand: RTL
====================

# zeroskip_expand

Streaming zero-insertion decoder: the inverse of the zero-skip packer. Per group it accepts a GROUP_SIZE-bit nonzero mask, then the packed nonzero activations in narrow beats, and re-inserts zeros. The output is one dense GROUP_SIZE-lane group in which lane i holds the k-th packed value when mask bit i is the k-th set bit, and zero otherwise. It sits on the read side of compressed activation storage, feeding the dense compute array.

## Interface
- GROUP_SIZE, 32, mask bits / dense lanes per group
- GROUP_NZ_MAX, 16, max packed values per group (8:32 and 16:32 share it); multiple of BEAT_LANES
- BEAT_LANES, 4, packed values per payload beat
- DATA_W, 8, bits per activation
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mask_valid  in  1  mask offered
- mask_ready  out  1  mask accepted when valid&&ready
- znz_din  in  GROUP_SIZE  nonzero mask, bit i = dense lane i nonzero
- data_valid  in  1  payload beat offered
- data_ready  out  1  beat accepted when valid&&ready
- act_enc_din  in  BEAT_LANES*DATA_W  packed values, lane 0 = earliest
- dense_valid  out  1  dense group available
- dense_ready  in  1  consumer accepts group
- act_dout  out  GROUP_SIZE*DATA_W  dense group, lane i at [i*DATA_W +: DATA_W]
- err  out  1  sticky overflow flag

## Operation
- FSM states: IDLE, COLLECT, OUT.
- IDLE: mask_ready=1, data_ready=0. On mask handshake: register mask; pop = popcount(mask), width $clog2(GROUP_SIZE)+1; eff = min(pop, GROUP_NZ_MAX); beats = ceil(eff/BEAT_LANES).
  - If beats==0: next state OUT, dense register loaded with all zeros.
  - Otherwise: beat_idx cleared, next state COLLECT.
- COLLECT: mask_ready=0, data_ready=1. Each accepted beat is written to packed buffer slots beat_idx*BEAT_LANES .. +BEAT_LANES-1, then beat_idx increments. On the beat where beat_idx==beats-1, the dense register is loaded by scatter and the next state is OUT.
  - The scatter uses the buffer including the beat being accepted that cycle.
  - Scatter rule: walk mask bits 0..GROUP_SIZE-1 with a running index k. A set bit i with k<eff gets act_dout[i]=buf[k] and k increments. All other lanes get 0.
- Lanes of the last beat at positions >= eff are ignored.
- Mask bits beyond the eff-th set bit produce zero lanes (truncation).
- OUT: dense_valid=1, mask_ready=0, data_ready=0. act_dout is held stable while dense_valid && !dense_ready. On handshake the next state is IDLE.
- data_valid in IDLE or OUT, and mask_valid in COLLECT or OUT, are not accepted. They produce no state change.
- act_dout is driven from a register only; it has no combinational path from the inputs.

## Timing
- Reset values: state IDLE, mask_ready=1, data_ready=0, dense_valid=0, act_dout=0, err=0. beat_idx, mask register and buffer are cleared.
- Mask handshake in cycle T with pop=0: dense_valid=1 from cycle T+1.
- Last payload beat accepted in cycle B: dense_valid=1 from cycle B+1.
- Back-to-back data_valid gives one beat per cycle. Minimum group period is beats+2 cycles (mask, beats, output); there is no overlap between groups.
- Dense handshake in cycle H: mask_ready=1 in cycle H+1.
- rst_n low at any time, including mid-COLLECT or OUT: returns to reset values immediately. Partial groups are discarded; no residual beats are consumed afterwards.
- beat_idx width is $clog2(GROUP_NZ_MAX/BEAT_LANES)+1 and never wraps within a group.

## Configuration
- ZEROSKIP_EXPAND_ERR_EN defined: on a mask handshake with pop>GROUP_NZ_MAX, err is set at T+1 and stays 1 until reset. Truncation proceeds as described above.
- Not defined: err is tied to 0 and there is no popcount compare logic for the flag. Truncation behaviour is identical.

## Test plan
- Mask 0x0000_0000 -> no beats consumed (data_ready never 1); dense_valid at T+1 with act_dout all zero; mask_ready again after the dense handshake.
- Mask 0x8000_0011, one beat {0x0A,0x0B,0x0C,0xFF} -> lane0=0x0A, lane4=0x0B, lane31=0x0C, other lanes 0; 0xFF ignored; dense_valid one cycle after the beat.
- Mask 0xFFFF_0000, 4 back-to-back beats of values 1..16 -> lanes 16..31 = 1..16, lanes 0..15 = 0; dense_valid at B+1 with B = 4th beat cycle.
- Mask 0xFFFF_FFFF with macro defined, 4 beats of values 1..16 -> err=1 from T+1; lanes 0..15 = 1..16, lanes 16..31 = 0; err stays 1 after the next group. Without the macro: same data, err=0.
- dense_ready held low for 5 cycles in OUT -> act_dout and dense_valid stable; mask_valid and data_valid ignored; return to IDLE the cycle after dense_ready=1.
- rst_n pulsed low after 2 of 4 beats -> all outputs at reset values; next group (mask 0x1, beat {0x55,...}) gives lane0=0x55 with no stale data.

Source files
------------

// File: rtl/zeroskip_expand.sv
// Zero-insertion decoder: takes a nonzero mask and the packed activations, and outputs one dense group.
// Optional sticky overflow flag is enabled by defining ZEROSKIP_EXPAND_ERR_EN.
module zeroskip_expand #(
    parameter int GROUP_SIZE   = 32,
    parameter int GROUP_NZ_MAX = 16,
    parameter int BEAT_LANES   = 4,
    parameter int DATA_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mask_valid,
    output logic                           mask_ready,
    input  logic [GROUP_SIZE-1:0]          znz_din,
    input  logic                           data_valid,
    output logic                           data_ready,
    input  logic [BEAT_LANES*DATA_W-1:0]   act_enc_din,
    output logic                           dense_valid,
    input  logic                           dense_ready,
    output logic [GROUP_SIZE*DATA_W-1:0]   act_dout,
    output logic                           err
);
    localparam int POP_W   = $clog2(GROUP_SIZE) + 1;
    localparam int BI_W    = $clog2(GROUP_NZ_MAX / BEAT_LANES) + 1;
    localparam int BUF_W   = GROUP_NZ_MAX * DATA_W;
    localparam int DENSE_W = GROUP_SIZE * DATA_W;

    typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

    state_t                state_q, state_d;
    logic [GROUP_SIZE-1:0] mask_q, mask_d;
    logic [POP_W-1:0]      eff_q, eff_d;
    logic [BI_W-1:0]       beats_q, beats_d;
    logic [BI_W-1:0]       beat_idx_q, beat_idx_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [DENSE_W-1:0]    dense_q, dense_d;

    logic [POP_W-1:0]      pop;
    logic [POP_W-1:0]      eff_in;
    logic [BI_W-1:0]       beats_in;
    logic [BUF_W-1:0]      buf_nxt;

    function automatic logic [POP_W-1:0] popcount(input logic [GROUP_SIZE-1:0] m);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            c = c + POP_W'(m[i]);
        end
        return c;
    endfunction

    // Set bit i takes the next packed value until eff values are used; everything else is zero.
    function automatic logic [DENSE_W-1:0] scatter(input logic [GROUP_SIZE-1:0] m,
                                                   input logic [POP_W-1:0]      eff,
                                                   input logic [BUF_W-1:0]      b);
        logic [DENSE_W-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            if (m[i] && (k < int'(eff))) begin
                d[i*DATA_W +: DATA_W] = b[k*DATA_W +: DATA_W];
                k++;
            end
        end
        return d;
    endfunction

    always_comb begin
        pop      = popcount(znz_din);
        eff_in   = (pop > POP_W'(GROUP_NZ_MAX)) ? POP_W'(GROUP_NZ_MAX) : pop;
        beats_in = BI_W'((int'(eff_in) + BEAT_LANES - 1) / BEAT_LANES);
        buf_nxt  = buf_q;
        for (int j = 0; j < BEAT_LANES; j++) begin
            buf_nxt[(int'(beat_idx_q) * BEAT_LANES + j) * DATA_W +: DATA_W] =
                act_enc_din[j*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        eff_d       = eff_q;
        beats_d     = beats_q;
        beat_idx_d  = beat_idx_q;
        buf_d       = buf_q;
        dense_d     = dense_q;
        mask_ready  = 1'b0;
        data_ready  = 1'b0;
        dense_valid = 1'b0;
        case (state_q)
            IDLE: begin
                mask_ready = 1'b1;
                if (mask_valid) begin
                    mask_d     = znz_din;
                    eff_d      = eff_in;
                    beats_d    = beats_in;
                    beat_idx_d = '0;
                    if (beats_in == '0) begin
                        dense_d = '0;
                        state_d = OUT;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    buf_d      = buf_nxt;
                    beat_idx_d = beat_idx_q + BI_W'(1);
                    // The scatter must see the beat arriving this cycle, so it reads buf_nxt.
                    if (beat_idx_q == beats_q - BI_W'(1)) begin
                        dense_d = scatter(mask_q, eff_q, buf_nxt);
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                dense_valid = 1'b1;
                if (dense_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            eff_q      <= '0;
            beats_q    <= '0;
            beat_idx_q <= '0;
            buf_q      <= '0;
            dense_q    <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            eff_q      <= eff_d;
            beats_q    <= beats_d;
            beat_idx_q <= beat_idx_d;
            buf_q      <= buf_d;
            dense_q    <= dense_d;
        end
    end

    assign act_dout = dense_q;

`ifdef ZEROSKIP_EXPAND_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && mask_valid && (pop > POP_W'(GROUP_NZ_MAX))) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
